// File: rtl/dz_count_scan_if.sv
// Control inputs and LED-matrix outputs of the dot-matrix up/down counter.
// The master side drives the buttons; the slave side is the counter itself.
interface dz_count_scan_if;
  logic       start;
  logic       pause;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;
  logic [3:0] cnt;
  logic       done;

  modport master (
    output start, pause, dir, load, load_val,
    input  row, colr, colg, cnt, done
  );

  modport slave (
    input  start, pause, dir, load, load_val,
    output row, colr, colg, cnt, done
  );
endinterface

// File: rtl/dz_count_scan.sv
// 8x8 dot-matrix up/down counter with tick prescaler, row scanning,
// start/pause/load control, warning colour and a blinking terminal state.
module dz_count_scan #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned SCAN_DIV  = 1,
  parameter int unsigned START_VAL = 5,
  parameter int unsigned WARN_VAL  = 2
) (
  input  logic            clk,
  input  logic            rst,
  dz_count_scan_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [2:0]      ridx_q, ridx_d;
  logic            blink_q, blink_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;
  logic [7:0]      row_q, row_d;
  logic [7:0]      colr_q, colr_d;
  logic [7:0]      colg_q, colg_d;

  logic            tick_c;
  logic            term_c;
  logic [CW-1:0]   term_val_c;
  logic [CW-1:0]   step_c;
  logic [CW-1:0]   load_sat_c;
  logic [7:0]      glyph_c;

  // Digit font: row 0 in the top byte, bit7 is the leftmost column.
  function automatic logic [7:0] glyph(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    case (d)
      4'd0:    g = 64'h3C666E7666663C00;
      4'd1:    g = 64'h181818181818_7E00 | 64'h0020000000000000;
      4'd2:    g = 64'h3C66060C30607E00;
      4'd3:    g = 64'h3C66061C06663C00;
      4'd4:    g = 64'h0C1C3C6C7E0C0C00;
      4'd5:    g = 64'h7E607C0606663C00;
      4'd6:    g = 64'h3C607C6666663C00;
      4'd7:    g = 64'h7E060C1830303000;
      4'd8:    g = 64'h3C66663C66663C00;
      4'd9:    g = 64'h3C66663E060C3800;
      default: g = 64'h0;
    endcase
    return 8'(g >> {~r, 3'b000});
  endfunction

  assign tick_c     = (presc_q == PW'(TICK_DIV - 1));
  assign term_val_c = dir_q ? CW'(9) : CW'(0);
  assign term_c     = (cnt_q == term_val_c);
  assign step_c     = dir_q ? (cnt_q + CW'(1)) : (cnt_q - CW'(1));
  assign load_sat_c = (bus.load_val > 4'd9) ? 4'd9 : bus.load_val;

  // Control FSM: state, count, prescaler, direction and blink
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    blink_d = blink_q;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (bus.load) begin
          cnt_d = load_sat_c;
        end else if (bus.start) begin
          state_d = RUN;
          dir_d   = bus.dir;
        end
      end
      RUN: begin
        presc_d = tick_c ? '0 : presc_q + PW'(1);
        if (bus.pause) begin
          state_d = PAUSE;
        end else if (tick_c) begin
          // A start from the terminal value goes back to DONE without stepping.
          if (!term_c) cnt_d = step_c;
          if (term_c || (step_c == term_val_c)) state_d = DONE;
        end
      end
      PAUSE: begin
        if (bus.load) begin
          state_d = IDLE;
          cnt_d   = load_sat_c;
          presc_d = '0;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        presc_d = tick_c ? '0 : presc_q + PW'(1);
        if (tick_c) blink_d = ~blink_q;
        if (bus.load) begin
          state_d = IDLE;
          cnt_d   = load_sat_c;
          presc_d = '0;
        end else if (bus.start) begin
          state_d = RUN;
          dir_d   = bus.dir;
          presc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Each visit to DONE starts on the lit phase.
    if (state_d != DONE) blink_d = 1'b0;
  end

  // Row scan and colour selection; row and columns register together
  always_comb begin
    scan_d = scan_q + SW'(1);
    ridx_d = ridx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      ridx_d = ridx_q + 3'd1;
    end
    row_d   = ~(8'd1 << ridx_q);
    glyph_c = glyph(cnt_q, ridx_q);
    colr_d  = 8'h00;
    colg_d  = 8'h00;
    if (state_q == DONE) begin
      if (!blink_q) begin
        colr_d = glyph_c;
        colg_d = glyph_c;
      end
    end else if (!dir_q && (cnt_q <= CW'(WARN_VAL))) begin
      colr_d = glyph_c;
    end else begin
      colg_d = glyph_c;
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CW'(START_VAL);
      presc_q <= '0;
      scan_q  <= '0;
      ridx_q  <= 3'd0;
      blink_q <= 1'b0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= 8'hFF;
      colr_q  <= 8'h00;
      colg_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      ridx_q  <= ridx_d;
      blink_q <= blink_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      row_q   <= row_d;
      colr_q  <= colr_d;
      colg_q  <= colg_d;
    end
  end

  assign bus.row  = row_q;
  assign bus.colr = colr_q;
  assign bus.colg = colg_q;
  assign bus.cnt  = cnt_q;
  assign bus.done = done_q;

endmodule
